cdc_fifo_wr_ctrl: RTL and testbench

//  Write-side pointer/flag controller for a dual-clock FIFO; lives entirely in the write clock domain.
//  - Feeds wr_ptr_bin to the gray-code synchroniser (stolen_cdc_gray, src side) that carries it to the read domain.
//  - Consumes the read pointer after that synchroniser has converted it back to binary (rd_ptr_sync).
//  - Produces the RAM write strobe/address, full/almost-full flags, fill level and error flags.

---
 rtl/cdc_fifo_wr_ctrl.sv | 76 +++++++
 tb/tb_cdc_fifo_wr_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for a dual-clock FIFO: mem_we combinational, flags registered from next pointer.
// Writes are refused while full (wr_ready=0); optional overflow counter under CDC_FIFO_OVF_CNT_EN.
module cdc_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  wr_req,
  output logic                  wr_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH:0]   wr_ptr_bin,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow,
  output logic                  ptr_err,
  output logic [7:0]            ovf_count
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L = PW'(AFULL_THRESH);

  logic                accept;
  logic [ADDR_WIDTH:0] wr_ptr_nxt;
  logic [ADDR_WIDTH:0] lvl_nxt;

  assign accept     = wr_req & ~full;
  assign wr_ready   = ~full;
  assign mem_we     = accept;
  assign mem_waddr  = wr_ptr_bin[ADDR_WIDTH-1:0];
  assign wr_ptr_nxt = wr_ptr_bin + {{ADDR_WIDTH{1'b0}}, accept};
  // Modular difference yields DEPTH when low bits match and MSBs differ.
  assign lvl_nxt    = wr_ptr_nxt - rd_ptr_sync;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      wr_ptr_bin  <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
      ptr_err     <= 1'b0;
    end else begin
      wr_ptr_bin  <= wr_ptr_nxt;
      wr_level    <= lvl_nxt;
      full        <= (lvl_nxt == DEPTH_L);
      almost_full <= (lvl_nxt >= AFULL_L);
      if (wr_req & full)
        overflow <= 1'b1;
      if (lvl_nxt > DEPTH_L)
        ptr_err <= 1'b1;
    end
  end

`ifdef CDC_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Saturating so a long stall cannot alias back to a small count.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      ovf_cnt_q <= 8'h00;
    else if (wr_req & full && ovf_cnt_q != 8'hFF)
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Directed vector bench for cdc_fifo_wr_ctrl (ADDR_WIDTH=4, AFULL_THRESH=12); outputs checked at negedge, before the commit edge.
module tb_cdc_fifo_wr_ctrl;

  logic       clk;
  logic       reset_p;
  logic       wr_req;
  logic       wr_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [4:0] wr_ptr_bin;
  logic [4:0] rd_ptr_sync;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;
  logic       ptr_err;
  logic [7:0] ovf_count;

  cdc_fifo_wr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .wr_req      (wr_req),
    .wr_ready    (wr_ready),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .wr_ptr_bin  (wr_ptr_bin),
    .rd_ptr_sync (rd_ptr_sync),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow),
    .ptr_err     (ptr_err),
    .ovf_count   (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       req;
    logic [4:0] rd;
    logic [4:0] e_ptr;
    logic       e_we;
    logic       e_full;
    logic       e_af;
    logic [4:0] e_lvl;
    logic       e_ovf;
    logic       e_perr;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [7:0] cnt(input int n);
`ifdef CDC_FIFO_OVF_CNT_EN
    return 8'(n);
`else
    return 8'(n * 0);
`endif
  endfunction

  function automatic vec_t mk(input logic r, input logic q, input logic [4:0] rd,
                              input logic [4:0] p, input logic we, input logic fl,
                              input logic af, input logic [4:0] lvl, input logic ovf,
                              input logic perr, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.rd = rd; v.e_ptr = p; v.e_we = we; v.e_full = fl;
    v.e_af = af; v.e_lvl = lvl; v.e_ovf = ovf; v.e_perr = perr; v.e_cnt = c;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_p = 1'b1; wr_req = 1'b0; rd_ptr_sync = 5'd0;
    @(posedge clk);
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic check(input string tag, input vec_t v);
    logic [3:0] e_addr;
    e_addr = v.e_ptr[3:0];
    n_vec++;
    if (wr_ptr_bin !== v.e_ptr || mem_we !== v.e_we || mem_waddr !== e_addr ||
        wr_ready !== ~v.e_full || full !== v.e_full || almost_full !== v.e_af ||
        wr_level !== v.e_lvl || overflow !== v.e_ovf || ptr_err !== v.e_perr ||
        ovf_count !== v.e_cnt) begin
      n_fail++;
      $display("FAIL %s: got ptr=%0d we=%b addr=%0d rdy=%b full=%b af=%b lvl=%0d ovf=%b perr=%b cnt=%0d; want ptr=%0d we=%b addr=%0d rdy=%b full=%b af=%b lvl=%0d ovf=%b perr=%b cnt=%0d",
               tag, wr_ptr_bin, mem_we, mem_waddr, wr_ready, full, almost_full, wr_level,
               overflow, ptr_err, ovf_count, v.e_ptr, v.e_we, e_addr, ~v.e_full, v.e_full,
               v.e_af, v.e_lvl, v.e_ovf, v.e_perr, v.e_cnt);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    if (v.rst) do_reset();
    @(negedge clk);
    wr_req = v.req; rd_ptr_sync = v.rd;
    #1;
    check(tag, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p = 1'b1; wr_req = 1'b0; rd_ptr_sync = 5'd0;

    // Fill from empty, then overflow, read-side free, simultaneous read/write, pointer fault.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++)
      vq.push_back(mk(0, 1, 0, 5'(k), 1, 0, (k >= 12), 5'(k), 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 16, 0, 1, 1, 16, 0, 0, cnt(0)));
    vq.push_back(mk(0, 1, 0, 16, 0, 1, 1, 16, 0, 0, cnt(0)));
    vq.push_back(mk(0, 1, 0, 16, 0, 1, 1, 16, 1, 0, cnt(1)));
    vq.push_back(mk(0, 1, 0, 16, 0, 1, 1, 16, 1, 0, cnt(2)));
    vq.push_back(mk(0, 0, 0, 16, 0, 1, 1, 16, 1, 0, cnt(3)));
    vq.push_back(mk(0, 1, 1, 16, 0, 1, 1, 16, 1, 0, cnt(3)));
    vq.push_back(mk(0, 0, 1, 16, 0, 0, 1, 15, 1, 0, cnt(4)));
    vq.push_back(mk(0, 1, 2, 16, 1, 0, 1, 15, 1, 0, cnt(4)));
    vq.push_back(mk(0, 0, 2, 17, 0, 0, 1, 15, 1, 0, cnt(4)));
    vq.push_back(mk(0, 0, 18, 17, 0, 0, 1, 15, 1, 0, cnt(4)));
    vq.push_back(mk(0, 0, 2, 17, 0, 0, 1, 31, 1, 1, cnt(4)));
    vq.push_back(mk(0, 0, 2, 17, 0, 0, 1, 15, 1, 1, cnt(4)));

    // Walk both pointers to 30 at level 0, then 16 writes across the wrap.
    for (int j = 0; j < 30; j++)
      vq.push_back(mk((j == 0), 1, 5'(j + 1), 5'(j), 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 30, 30, 0, 0, 0, 0, 0, 0, 0));
    for (int m = 0; m < 16; m++)
      vq.push_back(mk(0, 1, 30, 5'(30 + m), 1, 0, (m >= 12), 5'(m), 0, 0, 0));
    vq.push_back(mk(0, 0, 30, 14, 0, 1, 1, 16, 0, 0, 0));
    vq.push_back(mk(0, 1, 30, 14, 0, 1, 1, 16, 0, 0, cnt(0)));

    for (int i = 0; i < vq.size(); i++)
      run_vec($sformatf("vec%0d", i), vq[i]);

    // Asynchronous reset in the middle of a burst.
    run_vec("burst0", mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    run_vec("burst1", mk(0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    run_vec("burst2", mk(0, 1, 0, 2, 1, 0, 0, 2, 0, 0, 0));
    @(negedge clk);
    wr_req = 1'b1; rd_ptr_sync = 5'd0;
    #1;
    check("burst3", mk(0, 1, 0, 3, 1, 0, 0, 3, 0, 0, 0));
    #1;
    reset_p = 1'b1;
    #1;
    check("async_rst", mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    reset_p = 1'b0; wr_req = 1'b0;
    run_vec("post_rst_wr", mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    run_vec("post_rst_idle", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
